// File: rtl/mult_stall_unit.sv
// mult_stall_unit: single-clock shift-add multiplier for the Execute stage.
//
// Holds the pipeline through 'stall' until the product is ready. It handles
// signed and unsigned operands, can end early once the remaining multiplier
// bits are all zero, can be flushed, and carries a destination-register tag
// through to write-back.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-low
//   start      in   multiply request, accepted only in idle
//   is_signed  in   two's-complement operands when set, sampled with start
//   flush      in   abort an operation in load/run
//   op_a       in   multiplicand [WIDTH]
//   op_b       in   multiplier   [WIDTH]
//   tag_in     in   destination register index [TAG_W]
//   busy       out  operation in flight (load or run)
//   stall      out  pipeline hold request
//   done       out  one-cycle pulse, product/tag_out valid
//   product    out  result [2*WIDTH], held until the next done
//   tag_out    out  tag captured at start, held with product
module mult_stall_unit #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned EARLY_EXIT = 1,
  parameter int unsigned TAG_W      = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 busy,
  output logic                 stall,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [TAG_W-1:0]     tag_out
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              sgn_q, sgn_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic              neg_q, neg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]     product_q, product_d;
  logic [TAG_W-1:0]  tag_out_q, tag_out_d;

  logic [WIDTH-1:0]  abs_a, abs_b;

  // Magnitudes as unsigned WIDTH-bit values; the most negative input maps to
  // 2^(WIDTH-1), which still fits because the result is treated as unsigned.
  always_comb begin
    abs_a = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    abs_b = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sgn_d     = sgn_q;
    tag_d     = tag_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    neg_d     = neg_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    tag_out_d = tag_out_q;

    case (state_q)
      StIdle: begin
        // Flush wins over a simultaneous start: nothing is captured.
        if (!flush && start) begin
          a_d     = op_a;
          b_d     = op_b;
          sgn_d   = is_signed;
          tag_d   = tag_in;
          state_d = StLoad;
        end
      end

      StLoad: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          mcand_d  = {{WIDTH{1'b0}}, abs_a};
          mplier_d = abs_b;
          neg_d    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end

      StRun: begin
        if (flush) begin
          state_d = StIdle;
        end else begin
          // mcand_q is pre-shifted each cycle, so it always equals |a| << cnt.
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
          if ((cnt_d == CntMax) || ((EARLY_EXIT != 0) && (mplier_d == '0))) begin
            // Result registered on the way into StDone so it is valid with done.
            state_d   = StDone;
            product_d = neg_q ? -acc_d : acc_d;
            tag_out_d = tag_q;
          end
        end
      end

      StDone: begin
        // start is deliberately ignored here.
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      a_q       <= '0;
      b_q       <= '0;
      sgn_q     <= 1'b0;
      tag_q     <= '0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      neg_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
      tag_out_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sgn_q     <= sgn_d;
      tag_q     <= tag_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      neg_q     <= neg_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
      tag_out_q <= tag_out_d;
    end
  end

  always_comb begin
    busy    = (state_q == StLoad) || (state_q == StRun);
    // Combinational so the requesting instruction is held from its first cycle.
    stall   = busy | (start & (state_q == StIdle));
    done    = (state_q == StDone);
    product = product_q;
    tag_out = tag_out_q;
  end

endmodule

// File: tb/tb_mult_stall_unit.sv
`timescale 1ns / 1ps
module tb_mult_stall_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [4:0]  tag_in;

  // Early-exit instance.
  logic        busy1, stall1, done1;
  logic [31:0] product1;
  logic [4:0]  tag1;
  // Fixed-iteration instance.
  logic        busy0, stall0, done0;
  logic [31:0] product0;
  logic [4:0]  tag0;

  int n_checks = 0;
  int n_fail   = 0;

  mult_stall_unit #(.WIDTH(16), .EARLY_EXIT(1), .TAG_W(5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
    .busy(busy1), .stall(stall1), .done(done1), .product(product1), .tag_out(tag1)
  );

  mult_stall_unit #(.WIDTH(16), .EARLY_EXIT(0), .TAG_W(5)) dut0 (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .flush(flush),
    .op_a(op_a), .op_b(op_b), .tag_in(tag_in),
    .busy(busy0), .stall(stall0), .done(done0), .product(product0), .tag_out(tag0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sgn;
    logic [4:0]  tag;
    logic [31:0] prod;
    int          lat;   // start edge to done, early-exit instance
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one multiply and follows both instances to done. With disturb set,
  // a second start with different operands is pulsed while busy, the operand
  // inputs stay changed, and start is also raised in the early-exit DONE cycle.
  task automatic run_op(input vec_t v, input int idx, input bit disturb);
    int  lat1 = 0;
    int  lat0 = 0;
    int  st1  = 0;
    bit  poke = 0;
    op_a      = v.a;
    op_b      = v.b;
    is_signed = v.sgn;
    tag_in    = v.tag;
    start     = 1'b1;
    #1;
    check($sformatf("v%0d stall_on_start", idx), 64'(stall1), 64'd1);
    step();
    start = 1'b0;
    for (int n = 1; n <= 40 && (lat1 == 0 || lat0 == 0); n++) begin
      if (poke) begin
        start = 1'b0;
        poke  = 0;
        check($sformatf("v%0d start_in_done_ignored", idx), 64'(busy1), 64'd0);
      end
      if (lat1 == 0) begin
        if (done1) begin
          lat1 = n;
          check($sformatf("v%0d product_ee1", idx), 64'(product1), 64'(v.prod));
          check($sformatf("v%0d tag_ee1", idx), 64'(tag1), 64'(v.tag));
          check($sformatf("v%0d stall_in_done", idx), 64'(stall1), 64'd0);
          if (disturb) begin
            start = 1'b1;
            poke  = 1;
          end
        end else if (stall1) begin
          st1++;
        end
      end
      if (lat0 == 0 && done0) begin
        lat0 = n;
        check($sformatf("v%0d product_ee0", idx), 64'(product0), 64'(v.prod));
        check($sformatf("v%0d tag_ee0", idx), 64'(tag0), 64'(v.tag));
      end
      if (disturb && n == 2) begin
        start     = 1'b1;
        op_a      = ~v.a;
        op_b      = v.b ^ 16'h5A5A;
        is_signed = ~v.sgn;
        tag_in    = ~v.tag;
      end
      if (disturb && n == 3) start = 1'b0;
      if (lat1 == 0 || lat0 == 0) step();
    end
    start = 1'b0;
    check($sformatf("v%0d latency_ee1", idx), 64'(lat1), 64'(v.lat));
    check($sformatf("v%0d latency_ee0", idx), 64'(lat0), 64'd18);
    check($sformatf("v%0d stall_cycles", idx), 64'(st1), 64'(v.lat - 1));
    step();
    check($sformatf("v%0d done_pulse_ee1", idx), 64'(done1), 64'd0);
    check($sformatf("v%0d done_pulse_ee0", idx), 64'(done0), 64'd0);
    check($sformatf("v%0d product_hold", idx), 64'(product1), 64'(v.prod));
  endtask

  initial begin
    bit seen;

    vecs[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 5'd1,  32'hFFFE0001, 18};
    vecs[1] = '{16'hFFFD, 16'h0005, 1'b1, 5'd17, 32'hFFFFFFF1, 5};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 5'd2,  32'h40000000, 18};
    vecs[3] = '{16'h8000, 16'h8000, 1'b0, 5'd3,  32'h40000000, 18};
    vecs[4] = '{16'h8000, 16'h0001, 1'b1, 5'd4,  32'hFFFF8000, 3};
    vecs[5] = '{16'd1234, 16'd3,    1'b0, 5'd5,  32'd3702,     4};
    vecs[6] = '{16'h1234, 16'h0000, 1'b0, 5'd6,  32'h00000000, 3};
    vecs[7] = '{16'h0007, 16'hFFFE, 1'b1, 5'd7,  32'hFFFFFFF2, 4};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 5'd31, 32'h00000001, 3};
    vecs[9] = '{16'hFFFF, 16'h0001, 1'b0, 5'd9,  32'h0000FFFF, 3};

    rst = 1'b0; start = 1'b0; is_signed = 1'b0; flush = 1'b0;
    op_a = '0; op_b = '0; tag_in = '0;
    repeat (3) step();
    check("reset busy", 64'(busy1), 64'd0);
    check("reset stall", 64'(stall1), 64'd0);
    check("reset done", 64'(done1), 64'd0);
    check("reset product", 64'(product1), 64'd0);
    check("reset tag", 64'(tag1), 64'd0);
    rst = 1'b1;
    step();

    for (int i = 0; i < 10; i++) run_op(vecs[i], i, 1'b0);

    // Busy start with new operands, changed inputs and start in DONE all ignored.
    run_op(vecs[1], 100, 1'b1);

    // Flush three cycles into RUN.
    op_a = 16'hFFFF; op_b = 16'hFFFF; is_signed = 1'b0; tag_in = 5'd9; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush busy_ee1", 64'(busy1), 64'd0);
    check("flush stall_ee1", 64'(stall1), 64'd0);
    check("flush busy_ee0", 64'(busy0), 64'd0);
    check("flush product", 64'(product1), 64'hFFFFFFF1);
    check("flush tag", 64'(tag1), 64'd17);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 || done0) seen = 1;
      step();
    end
    check("flush no_done", 64'(seen), 64'd0);
    check("flush product_after", 64'(product0), 64'hFFFFFFF1);
    run_op(vecs[5], 200, 1'b0);

    // Flush in IDLE beats a simultaneous start.
    op_a = 16'h0003; op_b = 16'h0003; tag_in = 5'd12; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    check("idle_flush busy", 64'(busy1), 64'd0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done1 || done0) seen = 1;
      step();
    end
    check("idle_flush no_done", 64'(seen), 64'd0);
    check("idle_flush tag", 64'(tag1), 64'd5);

    // Reset mid-RUN clears everything.
    op_a = 16'h1234; op_b = 16'hFFFF; is_signed = 1'b0; tag_in = 5'd21; start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    check("pre_reset busy", 64'(busy1), 64'd1);
    rst = 1'b0;
    step();
    check("midrun_reset busy", 64'(busy1), 64'd0);
    check("midrun_reset stall", 64'(stall1), 64'd0);
    check("midrun_reset done", 64'(done1), 64'd0);
    check("midrun_reset product_ee1", 64'(product1), 64'd0);
    check("midrun_reset product_ee0", 64'(product0), 64'd0);
    check("midrun_reset tag", 64'(tag1), 64'd0);
    rst = 1'b1;
    step();
    run_op(vecs[7], 300, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
